fetch_sequencer: RTL

Program-sequencing stage that sits directly upstream of the datapath. It owns the 8-bit program counter and the run/halt state machine, and implements the top-level `start`/`done` handshake. Each cycle it presents `pc_out` to the combinational instruction memory and forwards the returned 9-bit word to the control LUT as `instr_out`. The datapath supplies the branch decision and offset, and the sequencer applies them to the next PC.

---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch_sequencer_if.sv | 21 ++
 rtl/pc_next_calc.sv | 15 +
 rtl/fetch_sequencer.sv | 42 ++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared sequencer states and program/instruction widths
package fetch_pkg;
  localparam int PC_W = 8;
  localparam int INSTR_W = 9;
  localparam int CNT_W = 16;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: start/done handshake, instruction fetch and branch bundle
interface fetch_sequencer_if;
  import fetch_pkg::*;
  logic start;
  logic [INSTR_W-1:0] instr_in;
  logic branch_taken;
  logic [PC_W-1:0] branch_offset;
  logic [PC_W-1:0] pc_out;
  logic [INSTR_W-1:0] instr_out;
  logic instr_valid;
  logic done;
  logic [CNT_W-1:0] instr_count;
  modport master (
    output start, instr_in, branch_taken, branch_offset,
    input pc_out, instr_out, instr_valid, done, instr_count
  );
  modport slave (
    input start, instr_in, branch_taken, branch_offset,
    output pc_out, instr_out, instr_valid, done, instr_count
  );
endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: next program counter from restart, hold, branch or increment
module pc_next_calc
  import fetch_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_offset,
  input  logic            restart,
  input  logic            hold,
  output logic [PC_W-1:0] pc_next
);
  // restart wins over hold, hold over branch; adds wrap modulo 2^PC_W
  always_comb
    pc_next = restart ? '0 : hold ? pc : branch_taken ? pc + branch_offset : pc + PC_W'(1);
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter, run/halt control and start/done handshake
module fetch_sequencer
  import fetch_pkg::*;
(
  input logic clk,
  input logic rst_n,
  fetch_sequencer_if.slave bus
);
  fetch_state_t state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [CNT_W-1:0] count;
  logic is_halt, valid;
  assign is_halt = bus.instr_in == HALT_INSTR;
  assign valid = state == RUN && !is_halt;
  pc_next_calc u_pc (
    .pc(pc),
    .branch_taken(bus.branch_taken),
    .branch_offset(bus.branch_offset),
    .restart(bus.start),
    .hold(!valid),
    .pc_next(pc_n)
  );
  // start restarts from any state; a halt word only stops a running program
  always_comb
    state_n = bus.start ? RUN : (state == RUN && is_halt) ? HALT : state;
  // state, PC and saturating executed-instruction counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      count <= bus.start ? '0 : (valid && count != '1) ? count + CNT_W'(1) : count;
    end
  assign bus.pc_out = pc;
  assign bus.instr_valid = valid;
  assign bus.instr_out = valid ? bus.instr_in : '0;
  assign bus.done = state == HALT;
  assign bus.instr_count = count;
endmodule
